// File: rtl/alu_divider.sv
// alu_divider: multi-cycle restoring shift-subtract divider, signed/unsigned, quotient or remainder
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             want_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] rem, dvd, dsr, quo, a_mag, b_mag;
  logic [WIDTH:0] rem_sh, diff;
  logic sign_q, sign_r, rem_sel;
  // Operand magnitudes and one restoring step; the extra top bit keeps divisors above 2^(WIDTH-1) exact
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    rem_sh = {rem, dvd[WIDTH-1]};
    diff = rem_sh - {1'b0, dsr};
  end
  // Sequencer: accept, WIDTH iterations, sign fixup, one-cycle done
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      div_by_zero <= 1'b0;
      count <= '0;
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
      quo <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      rem_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          rem_sel <= want_rem;
          sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          sign_r <= is_signed & a[WIDTH-1];
          dvd <= a_mag;
          dsr <= b_mag;
          rem <= '0;
          quo <= '0;
          count <= CW'(WIDTH - 1);
          div_by_zero <= (b == '0);
          done <= (b == '0);
          result <= (b == '0) ? (want_rem ? a : '1) : '0;
          state <= (b == '0) ? DONE : RUN;
        end
        RUN: begin
          rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          dvd <= dvd << 1;
          count <= count - 1'b1;
          state <= (count == '0) ? FIXUP : RUN;
        end
        FIXUP: begin
          result <= rem_sel ? (sign_r ? -rem : rem) : (sign_q ? -quo : quo);
          done <= 1'b1;
          state <= DONE;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
